// File: rtl/code_entry_checker.sv
// code_entry_checker
//   Collects four keypad digits, un-scrambles the stored 16-bit code and
//   compares the two. Emits one-cycle match/fail/nocode pulses, counts
//   consecutive failures and optionally enforces a timed lockout.
//
// Build option:
//   CODE_LOCKOUT_EN : when defined, MAX_FAIL consecutive failures enter a
//                     LOCK_CYCLES-long lockout; when undefined, locked is 0
//                     and fail_count simply saturates.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   key_valid     : key_digit is sampled this cycle
//   key_digit     : entered digit (0-9; larger values ignored)
//   key_clear     : discard the partial entry (wins over key_valid)
//   stored_code   : scrambled code (plaintext rotated left by one nibble)
//   code_valid    : a code has been programmed
//   match_pulse   : one cycle, entry matched
//   fail_pulse    : one cycle, entry mismatched
//   nocode_pulse  : one cycle, check ran with no programmed code
//   digit_count   : digits in the current entry (0-4)
//   fail_count    : consecutive failures, saturating at MAX_FAIL
//   locked        : lockout active
module code_entry_checker #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 1000
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               key_valid,
  input  logic [3:0]                         key_digit,
  input  logic                               key_clear,
  input  logic [15:0]                        stored_code,
  input  logic                               code_valid,
  output logic                               match_pulse,
  output logic                               fail_pulse,
  output logic                               nocode_pulse,
  output logic [2:0]                         digit_count,
  output logic [$clog2(MAX_FAIL+1)-1:0]      fail_count,
  output logic                               locked
);

  localparam int unsigned FW = $clog2(MAX_FAIL + 1);
  localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);

`ifdef CODE_LOCKOUT_EN
  localparam int unsigned TW = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {ENTRY, CHECK, LOCKOUT} state_t;

  logic [TW-1:0] timer, timer_d;
`else
  typedef enum logic {ENTRY, CHECK} state_t;
`endif

  state_t        state, state_d;
  logic [15:0]   entry, entry_d;
  logic [2:0]    count_d;
  logic [FW-1:0] fail_d, fail_inc;
  logic          match_d, fail_p_d, nocode_d;
  logic [15:0]   plain;

  // Undo the one-nibble left rotation of the stored code
  assign plain = {stored_code[3:0], stored_code[15:4]};

  // Saturating failure increment
  assign fail_inc = (fail_count == FAIL_MAX) ? fail_count : fail_count + FW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    entry_d  = entry;
    count_d  = digit_count;
    fail_d   = fail_count;
    match_d  = 1'b0;
    fail_p_d = 1'b0;
    nocode_d = 1'b0;
`ifdef CODE_LOCKOUT_EN
    timer_d  = timer;
`endif
    case (state)
      ENTRY: begin
        if (key_clear) begin
          entry_d = '0;
          count_d = '0;
        end else if (key_valid && (key_digit <= 4'd9)) begin
          entry_d = {entry[11:0], key_digit};
          count_d = digit_count + 3'd1;
          if (digit_count == 3'd3) state_d = CHECK;
        end
      end
      CHECK: begin
        entry_d = '0;
        count_d = '0;
        state_d = ENTRY;
        if (!code_valid) begin
          nocode_d = 1'b1;
        end else if (plain == entry) begin
          match_d = 1'b1;
          fail_d  = '0;
        end else begin
          fail_p_d = 1'b1;
          fail_d   = fail_inc;
`ifdef CODE_LOCKOUT_EN
          if (fail_inc == FAIL_MAX) begin
            state_d = LOCKOUT;
            timer_d = TIMER_LOAD;
          end
`endif
        end
      end
`ifdef CODE_LOCKOUT_EN
      LOCKOUT: begin
        if (timer == '0) begin
          state_d = ENTRY;
          fail_d  = '0;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
`endif
      default: state_d = ENTRY;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ENTRY;
      entry        <= '0;
      digit_count  <= '0;
      fail_count   <= '0;
      match_pulse  <= 1'b0;
      fail_pulse   <= 1'b0;
      nocode_pulse <= 1'b0;
    end else begin
      state        <= state_d;
      entry        <= entry_d;
      digit_count  <= count_d;
      fail_count   <= fail_d;
      match_pulse  <= match_d;
      fail_pulse   <= fail_p_d;
      nocode_pulse <= nocode_d;
    end
  end

`ifdef CODE_LOCKOUT_EN
  // Lockout timer and flag; locked mirrors the registered LOCKOUT state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer  <= '0;
      locked <= 1'b0;
    end else begin
      timer  <= timer_d;
      locked <= (state_d == LOCKOUT);
    end
  end
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_code_entry_checker.sv
// Testbench for code_entry_checker: table-driven vectors plus hand-written
// sequences for lockout / saturation and asynchronous reset.
module tb_code_entry_checker;

  localparam int unsigned MAX_FAIL    = 3;
  localparam int unsigned LOCK_CYCLES = 8;
  localparam int unsigned FW          = $clog2(MAX_FAIL + 1);
  localparam logic [15:0] GOOD = 16'h2341;  // plaintext 0x1234
  localparam logic [15:0] BAD  = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_valid;
  logic [3:0]    key_digit;
  logic          key_clear;
  logic [15:0]   stored_code;
  logic          code_valid;
  logic          match_pulse, fail_pulse, nocode_pulse;
  logic [2:0]    digit_count;
  logic [FW-1:0] fail_count;
  logic          locked;

  int n_cmp  = 0;
  int n_fail = 0;

  code_entry_checker #(.MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_digit    (key_digit),
    .key_clear    (key_clear),
    .stored_code  (stored_code),
    .code_valid   (code_valid),
    .match_pulse  (match_pulse),
    .fail_pulse   (fail_pulse),
    .nocode_pulse (nocode_pulse),
    .digit_count  (digit_count),
    .fail_count   (fail_count),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  d;
    logic        clr;
    logic [15:0] sc;
    logic        cv;
    logic [8:0]  exp;  // {match, fail, nocode, digit_count, fail_count, locked}
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic kv, logic [3:0] d, logic clr, logic [15:0] sc,
                             logic cv, logic m, logic f, logic n,
                             logic [2:0] dc, logic [1:0] fc);
    vec_t r;
    r.kv = kv; r.d = d; r.clr = clr; r.sc = sc; r.cv = cv;
    r.exp = {m, f, n, dc, fc, 1'b0};
    return r;
  endfunction

  function automatic logic [8:0] outs();
    return {match_pulse, fail_pulse, nocode_pulse, digit_count, 2'(fail_count), locked};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive four digits, then one idle cycle so the result pulse is visible
  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    logic [3:0] ds [4];
    ds[0] = a; ds[1] = b; ds[2] = c; ds[3] = d;
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_digit = ds[i];
      @(negedge clk);
    end
    key_valid = 1'b0; key_digit = 4'd0;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; key_valid = 1'b0; key_digit = 4'd0; key_clear = 1'b0;
    stored_code = GOOD; code_valid = 1'b1;

    // kv d clr sc cv | m f n dc fc
    tbl.push_back(v(1, 4'd1, 0, BAD,  1, 0, 0, 0, 3'd1, 2'd0));
    tbl.push_back(v(1, 4'd2, 0, BAD,  1, 0, 0, 0, 3'd2, 2'd0));
    tbl.push_back(v(1, 4'd3, 0, BAD,  0, 0, 0, 0, 3'd3, 2'd0));
    tbl.push_back(v(1, 4'd4, 0, BAD,  0, 0, 0, 0, 3'd4, 2'd0));
    tbl.push_back(v(1, 4'd9, 1, GOOD, 1, 1, 0, 0, 3'd0, 2'd0)); // CHECK ignores keys
    tbl.push_back(v(1, 4'd1, 0, GOOD, 1, 0, 0, 0, 3'd1, 2'd0)); // digit in pulse cycle
    tbl.push_back(v(1, 4'd2, 0, GOOD, 1, 0, 0, 0, 3'd2, 2'd0));
    tbl.push_back(v(1, 4'd3, 0, GOOD, 1, 0, 0, 0, 3'd3, 2'd0));
    tbl.push_back(v(1, 4'd5, 0, GOOD, 1, 0, 0, 0, 3'd4, 2'd0));
    tbl.push_back(v(0, 4'd0, 0, GOOD, 1, 0, 1, 0, 3'd0, 2'd1));
    tbl.push_back(v(1, 4'd1, 0, GOOD, 1, 0, 0, 0, 3'd1, 2'd1));
    tbl.push_back(v(1, 4'd2, 0, GOOD, 1, 0, 0, 0, 3'd2, 2'd1));
    tbl.push_back(v(1, 4'hA, 0, GOOD, 1, 0, 0, 0, 3'd2, 2'd1)); // out of range
    tbl.push_back(v(1, 4'hF, 0, GOOD, 1, 0, 0, 0, 3'd2, 2'd1));
    tbl.push_back(v(1, 4'd7, 1, GOOD, 1, 0, 0, 0, 3'd0, 2'd1)); // clear wins
    tbl.push_back(v(0, 4'd0, 0, GOOD, 1, 0, 0, 0, 3'd0, 2'd1));
    tbl.push_back(v(1, 4'd1, 0, GOOD, 1, 0, 0, 0, 3'd1, 2'd1));
    tbl.push_back(v(1, 4'd2, 0, GOOD, 1, 0, 0, 0, 3'd2, 2'd1));
    tbl.push_back(v(1, 4'd3, 0, GOOD, 1, 0, 0, 0, 3'd3, 2'd1));
    tbl.push_back(v(1, 4'd4, 0, GOOD, 1, 0, 0, 0, 3'd4, 2'd1));
    tbl.push_back(v(0, 4'd0, 0, GOOD, 1, 1, 0, 0, 3'd0, 2'd0));
    tbl.push_back(v(1, 4'd1, 0, GOOD, 1, 0, 0, 0, 3'd1, 2'd0));
    tbl.push_back(v(1, 4'd2, 0, GOOD, 1, 0, 0, 0, 3'd2, 2'd0));
    tbl.push_back(v(1, 4'd3, 0, GOOD, 1, 0, 0, 0, 3'd3, 2'd0));
    tbl.push_back(v(1, 4'd5, 0, GOOD, 1, 0, 0, 0, 3'd4, 2'd0));
    tbl.push_back(v(0, 4'd0, 0, GOOD, 1, 0, 1, 0, 3'd0, 2'd1));
    tbl.push_back(v(1, 4'd1, 0, GOOD, 0, 0, 0, 0, 3'd1, 2'd1));
    tbl.push_back(v(1, 4'd2, 0, GOOD, 0, 0, 0, 0, 3'd2, 2'd1));
    tbl.push_back(v(1, 4'd3, 0, GOOD, 0, 0, 0, 0, 3'd3, 2'd1));
    tbl.push_back(v(1, 4'd4, 0, GOOD, 0, 0, 0, 0, 3'd4, 2'd1));
    tbl.push_back(v(0, 4'd0, 0, GOOD, 0, 0, 0, 1, 3'd0, 2'd1)); // nocode
    tbl.push_back(v(0, 4'd0, 0, GOOD, 1, 0, 0, 0, 3'd0, 2'd1));

    #12;
    chk("reset_outputs", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      key_valid = tbl[i].kv; key_digit = tbl[i].d; key_clear = tbl[i].clr;
      stored_code = tbl[i].sc; code_valid = tbl[i].cv;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end
    key_valid = 1'b0; key_clear = 1'b0; stored_code = GOOD; code_valid = 1'b1;

    // Clear fail_count, then three consecutive failures
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("pre_lock_match", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0}));
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    chk("wrong1", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 3'd0, 2'd1, 1'b0}));
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    chk("wrong2", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 3'd0, 2'd2, 1'b0}));
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
`ifdef CODE_LOCKOUT_EN
    chk("wrong3_locked", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b1}));
    // Digits pressed during lockout must be ignored
    cnt = 0;
    key_valid = 1'b1; key_digit = 4'd1;
    while (locked && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("locked_cycles", 32'(cnt), 32'(LOCK_CYCLES));
    chk("after_lock_state", 32'(outs()), 32'd0);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("after_lock_match", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0}));
`else
    chk("wrong3", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b0}));
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    chk("wrong4_sat", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b0}));
    enter4(4'd9, 4'd9, 4'd9, 4'd9);
    chk("wrong5_sat", 32'(outs()), 32'({1'b0, 1'b1, 1'b0, 3'd0, 2'd3, 1'b0}));
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("sat_match", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0}));
`endif

    // Reset after repeated failures (inside lockout when it is compiled in)
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_lock", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after two digits
    key_valid = 1'b1; key_digit = 4'd1;
    @(negedge clk);
    key_digit = 4'd2;
    @(negedge clk);
    key_valid = 1'b0;
    chk("two_digits", 32'(digit_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_entry", 32'(outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    chk("post_reset_match", 32'(outs()), 32'({1'b1, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0}));
    @(negedge clk);
    chk("pulse_one_cycle", 32'(outs()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
